// File: rtl/pipelined_subtractor.sv
// Carry-chunked pipelined subtractor: A - B, one borrow chunk per stage.
// Global-stall valid/ready pipeline; outputs are zeroed when not valid.
module pipelined_subtractor #(
  parameter int INP_DW     = 8,
  parameter int NUM_STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INP_DW:0]   minuend,
  input  logic [INP_DW-1:0] subtrahend,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INP_DW:0]   diff,
  output logic              underflow
);

  localparam int W  = INP_DW + 1;
  localparam int NS = NUM_STAGES;
  localparam int CW = (W + NS - 1) / NS;

  logic [W-1:0] a_q  [NS];
  logic [W-1:0] a_d  [NS];
  logic [W-1:0] b_q  [NS];
  logic [W-1:0] b_d  [NS];
  logic [W-1:0] r_q  [NS];
  logic [W-1:0] r_d  [NS];
  logic         bo_q [NS];
  logic         bo_d [NS];
  logic         v_q  [NS];
  logic         v_d  [NS];
  logic         adv;

  assign out_valid = v_q[NS-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign diff      = out_valid ? r_q[NS-1] : '0;
  assign underflow = out_valid & bo_q[NS-1];

  always_comb begin
    logic [W-1:0] a_s;
    logic [W-1:0] b_s;
    logic [W-1:0] r_s;
    logic         br;
    logic         v_s;
    int           lo;
    int           hi;
    a_s = '0;
    b_s = '0;
    r_s = '0;
    br  = 1'b0;
    v_s = 1'b0;
    lo  = 0;
    hi  = 0;
    for (int k = 0; k < NS; k++) begin
      if (k == 0) begin
        a_s = minuend;
        b_s = {1'b0, subtrahend};
        r_s = '0;
        br  = 1'b0;
        v_s = in_valid;
      end else begin
        a_s = a_q[k-1];
        b_s = b_q[k-1];
        r_s = r_q[k-1];
        br  = bo_q[k-1];
        v_s = v_q[k-1];
      end
      lo = k * CW;
      hi = (k + 1) * CW - 1;
      // bits outside [lo,hi] (or an empty chunk) pass borrow through
      for (int i = 0; i < W; i++) begin
        if (i >= lo && i <= hi) begin
          r_s[i] = a_s[i] ^ b_s[i] ^ br;
          br     = (~a_s[i] & b_s[i])
                 | (~(a_s[i] ^ b_s[i]) & br);
        end
      end
      a_d[k]  = a_s;
      b_d[k]  = b_s;
      r_d[k]  = r_s;
      bo_d[k] = br;
      v_d[k]  = v_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NS; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        r_q[k]  <= '0;
        bo_q[k] <= 1'b0;
        v_q[k]  <= 1'b0;
      end
    end else if (adv) begin
      a_q  <= a_d;
      b_q  <= b_d;
      r_q  <= r_d;
      bo_q <= bo_d;
      v_q  <= v_d;
    end
  end

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Bench: three depths (4, 1, 9) share stimulus; each has its own
// in-order scoreboard fed from an A-B arithmetic model.
module tb_pipelined_subtractor;

  localparam int NSV [3] = '{4, 1, 9};

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [8:0] minuend;
  logic [7:0] subtrahend;
  logic       out_ready;
  logic       ir [3];
  logic       ov [3];
  logic [8:0] df [3];
  logic       uf [3];

  int tests = 0;
  int fails = 0;

  logic [9:0] fifo [3][1024];
  int         wp [3];
  int         rp [3];
  logic       pstall [3];
  logic [8:0] pdf [3];
  logic       puf [3];

  typedef struct {
    logic [8:0] a;
    logic [7:0] b;
    logic [8:0] d;
    logic       u;
  } vec_t;

  vec_t tv [6];

  always #5 clk = ~clk;

  pipelined_subtractor #(.INP_DW(8), .NUM_STAGES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .minuend(minuend), .subtrahend(subtrahend),
    .out_valid(ov[0]), .out_ready(out_ready),
    .diff(df[0]), .underflow(uf[0]));

  pipelined_subtractor #(.INP_DW(8), .NUM_STAGES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .minuend(minuend), .subtrahend(subtrahend),
    .out_valid(ov[1]), .out_ready(out_ready),
    .diff(df[1]), .underflow(uf[1]));

  pipelined_subtractor #(.INP_DW(8), .NUM_STAGES(9)) u9 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .minuend(minuend), .subtrahend(subtrahend),
    .out_valid(ov[2]), .out_ready(out_ready),
    .diff(df[2]), .underflow(uf[2]));

  function automatic logic [9:0] model(logic [8:0] a, logic [7:0] b);
    int x;
    x = int'(a) - int'(b);
    return {x < 0, 9'((x + 512) % 512)};
  endfunction

  task automatic chk(input bit ok, input string nm, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        wp[d] = 0;
        rp[d] = 0;
        pstall[d] = 1'b0;
      end else begin
        if (pstall[d]) begin
          chk(ov[d] == 1'b1, "hold_valid", d, 32'(ov[d]), 1);
          chk({uf[d], df[d]} == {puf[d], pdf[d]}, "hold_data", d,
              32'({uf[d], df[d]}), 32'({puf[d], pdf[d]}));
        end
        chk(ir[d] == (!ov[d] || out_ready), "in_ready", d,
            32'(ir[d]), 32'(!ov[d] || out_ready));
        if (!ov[d])
          chk({uf[d], df[d]} == 10'd0, "idle_zero", d,
              32'({uf[d], df[d]}), 0);
        if (ov[d] && out_ready) begin
          chk(rp[d] != wp[d], "extra_beat", d, 32'(rp[d]), 32'(wp[d]));
          if (rp[d] != wp[d]) begin
            chk({uf[d], df[d]} == fifo[d][rp[d] % 1024], "data", d,
                32'({uf[d], df[d]}), 32'(fifo[d][rp[d] % 1024]));
            rp[d]++;
          end
        end
        if (in_valid && ir[d]) begin
          fifo[d][wp[d] % 1024] = model(minuend, subtrahend);
          wp[d]++;
        end
        pstall[d] = ov[d] && !out_ready;
        pdf[d] = df[d];
        puf[d] = uf[d];
      end
    end
  end

  task automatic rand_beat();
    minuend    = 9'($urandom);
    subtrahend = 8'($urandom);
  endtask

  // pattern of in_valid bits, checked against out_valid at each depth
  task automatic run_pattern(input logic [15:0] pat, input int n,
                             input bit use_tv, input vec_t v);
    int j;
    in_valid = pat[0];
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      in_valid = (c < n) ? pat[c] : 1'b0;
      if (!use_tv) rand_beat();
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        j = c - NSV[d];
        chk(ov[d] == ((j >= 0 && j < n) ? pat[j] : 1'b0),
            "valid_pattern", d, 32'(ov[d]), 32'(j));
        if (use_tv && ov[d]) begin
          chk(df[d] == v.d, "tv_diff", d, 32'(df[d]), 32'(v.d));
          chk(uf[d] == v.u, "tv_uflow", d, 32'(uf[d]), 32'(v.u));
        end
      end
    end
  endtask

  initial begin
    vec_t none;
    int   idx;
    none = '{a: 9'd0, b: 8'd0, d: 9'd0, u: 1'b0};
    tv[0] = '{a: 9'h1FE, b: 8'hFF, d: 9'h0FF, u: 1'b0};
    tv[1] = '{a: 9'h100, b: 8'h01, d: 9'h0FF, u: 1'b0};
    tv[2] = '{a: 9'h000, b: 8'h01, d: 9'h1FF, u: 1'b1};
    tv[3] = '{a: 9'h1FF, b: 8'h00, d: 9'h1FF, u: 1'b0};
    tv[4] = '{a: 9'h000, b: 8'hFF, d: 9'h101, u: 1'b1};
    tv[5] = '{a: 9'h0FF, b: 8'hFF, d: 9'h000, u: 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    minuend = '0;
    subtrahend = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk(ov[d] == 1'b0, "rst_valid", d, 32'(ov[d]), 0);
      chk({uf[d], df[d]} == 10'd0, "rst_data", d,
          32'({uf[d], df[d]}), 0);
      chk(ir[d] == 1'b1, "rst_ready", d, 32'(ir[d]), 1);
    end
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      minuend = tv[t].a;
      subtrahend = tv[t].b;
      run_pattern(16'h0001, 1, 1'b1, tv[t]);
    end

    run_pattern(16'b11001, 5, 1'b0, none);

    // back-to-back stream of 64 beats
    in_valid = 1'b1;
    rand_beat();
    for (int c = 1; c <= 64 + 9; c++) begin
      @(posedge clk);
      #1;
      in_valid = (c < 64);
      rand_beat();
      @(negedge clk);
      if (c >= NSV[0] && c < NSV[0] + 64)
        chk(ov[0] == 1'b1, "stream_gap", 0, 32'(ov[0]), 1);
    end

    // backpressure: 8 beats, out_ready low for 5 cycles
    idx = 0;
    in_valid = 1'b1;
    rand_beat();
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 6 && c < 11);
      @(negedge clk);
      if (in_valid && ir[0]) idx++;
      @(posedge clk);
      #1;
      if (idx >= 8) in_valid = 1'b0;
      else if (ir[0]) rand_beat();
    end
    chk(idx == 8, "bp_count", 0, 32'(idx), 8);
    out_ready = 1'b1;

    // randomized traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_beat();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk(wp[d] == rp[d], "drain", d, 32'(rp[d]), 32'(wp[d]));

    // reset with 3 beats in flight
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_beat();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk(ov[d] == 1'b0, "mid_rst_valid", d, 32'(ov[d]), 0);
      chk({uf[d], df[d]} == 10'd0, "mid_rst_data", d,
          32'({uf[d], df[d]}), 0);
      chk(ir[d] == 1'b1, "mid_rst_ready", d, 32'(ir[d]), 1);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        chk(ov[d] == 1'b0, "stale_beat", d, 32'(ov[d]), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_subtractor.md
# pipelined_subtractor

Carry-chunked pipelined subtractor that takes an `INP_DW+1`-bit minuend (the widened sum produced by the team's pipelined adder) and an `INP_DW`-bit subtrahend, and returns the difference plus an underflow flag. It recovers an operand from a sum in the datapath. The borrow chain is split into `NUM_STAGES` chunks, one per register stage, so the critical path is one chunk wide. A valid/ready handshake with global stall carries results to the consumer.

## Interface
- `INP_DW`, 8, subtrahend width; minuend and difference are `INP_DW+1` bits.
- `NUM_STAGES`, 4, pipeline stages (≥1, ≤ `INP_DW+1`); also the number of borrow chunks.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  reset, synchronous and active-high.
- `in_valid`  input  1  operands valid this cycle.
- `in_ready`  output  1  block accepts operands this cycle.
- `minuend`  input  `INP_DW+1`  value A.
- `subtrahend`  input  `INP_DW`  value B, zero-extended to `INP_DW+1`.
- `out_valid`  output  1  `diff`/`underflow` valid.
- `out_ready`  input  1  consumer accepts result this cycle.
- `diff`  output  `INP_DW+1`  (A − B) mod 2^(INP_DW+1).
- `underflow`  output  1  1 iff A < B (final borrow out).

## Operation
- W = `INP_DW+1`. CW = ceil(W / `NUM_STAGES`). Chunk k (0-based) covers bits [k·CW, min((k+1)·CW, W) − 1]. Trailing chunks may be narrower or empty. An empty chunk passes the borrow through unchanged.
- Stage k+1 registers the following:
  - chunk k result = A_k − B_k − borrow_in. Stage 1 uses borrow_in = 0.
  - borrow out.
  - the already-computed lower chunks.
  - the not-yet-consumed upper operand chunks, skewed forward.
  - a valid bit.
- Global advance: `adv` = `!out_valid || out_ready`. `in_ready` = `adv` (combinational).
- When `adv` = 1, every stage loads from its predecessor. Stage 1 loads the operands and `in_valid`. A beat is accepted iff `in_valid && in_ready`.
- When `adv` = 0, all stages hold, including bubbles. No compaction.
- `diff` = concatenation of all chunk results held in the last stage. `underflow` = last stage borrow out. `out_valid` = last stage valid bit.
- Data registers of invalid stages are don't-care internally. Exception: `diff`/`underflow` are forced to 0 whenever `out_valid` = 0.
- Reset:
  - all valid bits and all data registers clear to 0.
  - outputs after reset: `out_valid`=0, `diff`=0, `underflow`=0, `in_ready`=1.
- Reset asserted mid-operation drops every in-flight beat. Nothing is emitted after reset deasserts.

## Timing
- Latency: a beat accepted at edge t appears with `out_valid`=1 after edge t+`NUM_STAGES−1`, i.e. visible during cycle t+`NUM_STAGES`, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while `out_ready`=1.
- Stall: with `out_valid`=1 and `out_ready`=0, the following hold stable until the handshake completes:
  - `diff`, `underflow` and `out_valid`.
  - `in_ready`=0.
- `in_ready` depends combinationally on `out_ready`. There is no other combinational input→output path.
- Simultaneous output handshake and input accept in the same cycle: both occur and the pipeline shifts by one.
- `in_valid`=0 while `adv`=1 inserts a bubble. The bubble shifts to the output as `out_valid`=0.
- `NUM_STAGES`=1: one register stage, latency 1 cycle, full-width subtract in one cycle.

## Test plan
- Reset, then defaults (INP_DW=8, NUM_STAGES=4, CW=3): A=9'h1FE, B=8'hFF, `out_ready`=1 → 4 cycles later `diff`=9'h0FF, `underflow`=0, `out_valid` high for exactly 1 cycle.
- Borrow across every chunk: A=9'h100, B=8'h01 → `diff`=9'h0FF, `underflow`=0. A=9'h000, B=8'h01 → `diff`=9'h1FF, `underflow`=1.
- Back-to-back stream: 64 random (A, B) pairs, `in_valid` held high, `out_ready`=1 → 64 consecutive results, in order, each matching the A−B model, no gaps.
- Backpressure: stream 8 beats and hold `out_ready`=0 for 5 cycles mid-stream → output held stable, `in_ready`=0 throughout, no loss or duplication, order preserved.
- Bubbles: `in_valid` pattern 1,0,0,1,1 → `out_valid` pattern 1,0,0,1,1 at latency 4.
- Reset mid-stream: assert `rst` for 1 cycle with 3 beats in flight → next cycle `out_valid`=0, `diff`=0, `underflow`=0, `in_ready`=1; no stale beat emerges. Repeat the directed cases with NUM_STAGES=1 and NUM_STAGES=9.
